// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer: one valid/ready input, one-entry holding register per output channel.
// Optional STREAM_DEMUX_BCAST_EN adds in_bcast, which loads every channel from one input word.
//
// Handshake (both sides): a word moves across an interface at a rising clock edge exactly when
// valid and ready are both high at that edge; a valid source holds its data stable until then.
module stream_demux #(
    parameter int width    = 8,
    parameter int channels = 4,
    localparam int SELW    = (channels > 1) ? $clog2(channels) : 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [width-1:0]            in_data,
    input  logic [SELW-1:0]             in_sel,
`ifdef STREAM_DEMUX_BCAST_EN
    input  logic                        in_bcast,
`endif
    output logic [channels-1:0]         out_valid,
    input  logic [channels-1:0]         out_ready,
    output logic [channels*width-1:0]   out_data,
    output logic                        sel_err
);

    logic [channels-1:0] v_q, v_d;
    logic [width-1:0]    hold_q [channels];
    logic [width-1:0]    hold_d [channels];
    logic                sel_err_q, sel_err_d;

    logic [channels-1:0] sel_hit;
    logic [channels-1:0] ch_free;
    logic [channels-1:0] acc;
    logic                sel_ok;
    logic                bcast;

`ifdef STREAM_DEMUX_BCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    always_comb begin
        sel_hit = '0;
        ch_free = '0;
        for (int i = 0; i < channels; i++) begin
            sel_hit[i] = (32'(in_sel) == 32'(i));
            // A full channel whose consumer takes its word at this edge can accept a new one.
            ch_free[i] = !v_q[i] || out_ready[i];
        end
        // An out-of-range select matches no channel, so it is never ready.
        sel_ok = |sel_hit;
    end

    always_comb begin
        in_ready  = 1'b0;
        acc       = '0;
        sel_err_d = sel_err_q;
        v_d       = v_q;
        for (int i = 0; i < channels; i++) begin
            hold_d[i] = hold_q[i];
        end

        if (bcast) begin
            in_ready = &ch_free;
            acc      = (in_valid && in_ready) ? {channels{1'b1}} : '0;
        end else begin
            in_ready = |(sel_hit & ch_free);
            acc      = {channels{in_valid}} & sel_hit & ch_free;
            if (in_valid && !sel_ok) begin
                sel_err_d = 1'b1;
            end
        end

        for (int i = 0; i < channels; i++) begin
            if (acc[i]) begin
                hold_d[i] = in_data;
                v_d[i]    = 1'b1;
            end else if (out_ready[i]) begin
                v_d[i]    = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_q       <= '0;
            sel_err_q <= 1'b0;
            for (int i = 0; i < channels; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            v_q       <= v_d;
            sel_err_q <= sel_err_d;
            for (int i = 0; i < channels; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < channels; i++) begin
            out_data[i*width +: width] = hold_q[i];
        end
    end

    assign out_valid = v_q;
    assign sel_err   = sel_err_q;

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-N demultiplexer with a valid/ready handshake. It is the inverse of the team's parameterised packed-bus mux.
- Accepts one word plus a channel select on a single input stream. Steers the word into a one-entry holding register on the selected output channel.
- Used in the CPU datapath to fan a single producer (e.g. the memory read-data path) out to several consumers (register file, ALU operand latch, IR).
- Each channel drains independently, so a stalled consumer blocks only its own channel.

Parameters:
- width, 8, data word width in bits.
- channels, 4, number of output channels; range 2..16; need not be a power of two.
- SELW (localparam), log2(channels) using the ceiling-log2 function already in use, select width.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  width  input word.
- in_sel  input  SELW  destination channel index.
- out_valid  output  channels  bit i: channel i holds a word.
- out_ready  input  channels  bit i: consumer i takes the word this cycle.
- out_data  output  channels*width  packed; channel i occupies bits [(i+1)*width-1 : i*width].
- sel_err  output  1  sticky flag: an out-of-range select was presented with in_valid.

Behaviour:
- Reset (reset_n low, asynchronous): out_valid=0, all out_data=0, sel_err=0. Holding registers clear immediately, with no wait for a clock edge.
- Per channel i: a holding register hold[i] and a flag v[i]. out_valid[i]=v[i]. Output slice i of out_data = hold[i].
- in_ready (combinational):
  - = (in_sel < channels) & (!v[in_sel] | out_ready[in_sel]).
  - Depends only on the selected channel. Full-but-draining-this-cycle counts as ready.
- Accept: in_valid & in_ready at an edge. Then hold[in_sel] <= in_data and v[in_sel] <= 1.
  - Latency: word is visible on out_valid/out_data the cycle after acceptance.
  - No combinational in-to-out path.
- Drain: v[i] & out_ready[i] at an edge clears v[i], unless the same edge also accepts into channel i.
- Simultaneous accept and drain on the same channel:
  - Old word is consumed, new word loaded, and v[i] stays 1.
  - Gives full throughput of 1 word/cycle per channel.
- Simultaneous drains on several channels are independent. Accept affects only the selected channel.
- Stability: while v[i] & !out_ready[i], hold[i] must not change.
- Empty channel: hold[i] retains its last value, which is don't-care to the consumer. out_ready[i] with v[i]=0 has no effect.
- Out-of-range select (in_sel >= channels, only possible when channels is not a power of two):
  - in_ready=0 and the word is not accepted.
  - If in_valid is also high, sel_err <= 1 at the edge.
  - sel_err clears only on reset.
- in_valid low: in_ready still reflects the selected channel, but no state changes occur.
- Reset mid-transfer: all held words are discarded; the producer must re-send.
- Input handshake rule: the producer holds in_data and in_sel stable while in_valid & !in_ready. The block does not check this rule.

Optional Feature:
- Macro: STREAM_DEMUX_BCAST_EN.
- When defined:
  - Adds input port in_bcast (1 bit).
  - When in_bcast=1, in_sel is ignored.
  - in_ready = AND over all channels of (!v[i] | out_ready[i]).
  - On accept, every channel loads in_data and sets v[i]=1 in the same cycle.
  - sel_err is not set by a broadcast.
- When undefined: no in_bcast port; behaviour as above.

Test Plan:
- Reset + single send: width=8, channels=4. Release reset_n; send in_data=0xA5, in_sel=2 with out_ready=0 -> next cycle out_valid=4'b0100, slice 2=0xA5, other slices 0x00, in_ready for sel 2 drops to 0.
- Backpressure: hold out_ready[2]=0 for 5 cycles, then present 0x3C to sel 2 -> in_ready=0, slice 2 stays 0xA5. Raise out_ready[2] -> same edge drains 0xA5 and loads 0x3C; out_valid[2] stays 1.
- Streaming: out_ready=4'b1111; send 0x00..0x0F round-robin over sel 0..3 every cycle -> in_ready constantly 1; each channel shows its word exactly one cycle later; no loss or duplication.
- Independence: channel 1 full and stalled; send 0x77 to sel 3 -> accepted; out_valid=4'b1010; channel 1 data unchanged.
- Out-of-range: channels=3; in_valid=1, in_sel=3 -> in_ready=0, sel_err=1 next cycle and stays 1 until reset_n pulse; no out_valid change.
- Reset mid-operation: channels 0 and 2 full; assert reset_n low between clock edges -> out_valid=0 and data 0 immediately, before the next edge. With STREAM_DEMUX_BCAST_EN: in_bcast=1, in_data=0x5A with all empty -> next cycle out_valid=4'b1111, all slices 0x5A.
